// File: rtl/fft_frame_loader_if.sv
// Frame-loader bus: sample stream in, frame bank and start/done handshake out to fft_256.
// master is the loader itself; slave is the surrounding sample source and FFT.
interface fft_frame_loader_if #(
    parameter int WIDTH = 12,
    parameter int N     = 256
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             sample_ready;
    logic [WIDTH-1:0] time_samples [0:N-1];
    logic             start;
    logic             done;
    logic             busy;
    logic [7:0]       frame_id;

    modport master (
        input  sample_in, sample_valid, done,
        output sample_ready, time_samples, start, busy, frame_id
    );

    modport slave (
        output sample_in, sample_valid, done,
        input  sample_ready, time_samples, start, busy, frame_id
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Collects a sample stream into an N-entry fill buffer, copies full frames into a
// stable bank for fft_256, pulses start and waits for a done rising edge.
module fft_frame_loader #(
    parameter int WIDTH = 12,
    parameter int N     = 256
) (
    input  logic                clk,
    input  logic                rst,
    fft_frame_loader_if.master  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] fill    [0:N-1];
    logic [WIDTH-1:0] frame_q [0:N-1];
    logic [7:0]       frame_id_q;
    logic             done_q;
    logic             full;
    logic             accept;
    logic             load;
    logic             done_rise;

    assign full      = (count == CW'(N));
    assign accept    = bus.sample_valid && !full;
    assign load      = (state == IDLE) && full;
    assign done_rise = bus.done && !done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only a fresh rising edge of done may end BUSY; a level left high is ignored.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load) state_next = START;
            START:   state_next = BUSY;
            BUSY:    if (done_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.start        = (state == START);
        bus.busy         = (state != IDLE);
        bus.sample_ready = !full;
    end

    assign bus.time_samples = frame_q;
    assign bus.frame_id     = frame_id_q;

    // Accept and load are mutually exclusive because a full buffer drops ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            done_q     <= 1'b0;
            frame_id_q <= 8'd0;
            for (int i = 0; i < N; i++) begin
                fill[i]    <= '0;
                frame_q[i] <= '0;
            end
        end else begin
            done_q <= bus.done;
            if (load) begin
                frame_q <= fill;
                count   <= '0;
            end else if (accept) begin
                fill[count[IW-1:0]] <= bus.sample_in;
                count               <= count + 1'b1;
            end
            if (state == START) begin
                frame_id_q <= frame_id_q + 8'd1;
            end
        end
    end
endmodule
